// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle byte/word data memory that answers CPU strobes after LATENCY wait states.
// Build option: define DMEM_BYTE_SIGNEXT_EN for sign-extended byte loads (default zero-extends).
module dmem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write_b,
  input  logic        mem_write_w,
  input  logic        mem_read_b,
  input  logic        mem_read_w,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);
  localparam int         DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  typedef struct packed {
    logic [ADDR_BITS-1:0] a;
    logic [31:0]          data;
    logic                 wr_b;
    logic                 wr_w;
    logic                 rd_b;
    logic                 rd_w;
    logic                 bad;
  } req_t;

  logic [7:0] mem [DEPTH];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  req_t                 live, acc;
  logic [2:0]           n_strb;
  logic                 any_strb;
  logic                 do_acc;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] a0, a1, a2, a3;
  logic [7:0]           b0;
  logic [31:0]          rd_byte;

  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_BITS];

  // Legality is judged on the live strobes at capture and carried with the request.
  always_comb begin
    n_strb    = 3'(mem_write_b) + 3'(mem_write_w) + 3'(mem_read_b) + 3'(mem_read_w);
    any_strb  = (n_strb != 3'd0);
    live.a    = addr[ADDR_BITS-1:0];
    live.data = wdata;
    live.wr_b = mem_write_b;
    live.wr_w = mem_write_w;
    live.rd_b = mem_read_b;
    live.rd_w = mem_read_w;
    live.bad  = (n_strb > 3'd1) || ((mem_read_w || mem_write_w) && (addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    acc     = req_q;
    do_acc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_strb) begin
          req_d = live;
          cnt_d = LAT;
          if (LAT == 4'd0) begin
            // Zero wait states: the access happens on the capture edge itself.
            state_d = DONE;
            acc     = live;
            do_acc  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          do_acc  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a0 = acc.a;
    a1 = acc.a + ADDR_BITS'(1);
    a2 = acc.a + ADDR_BITS'(2);
    a3 = acc.a + ADDR_BITS'(3);
    b0 = mem[a0];
`ifdef DMEM_BYTE_SIGNEXT_EN
    rd_byte = {{24{b0[7]}}, b0};
`else
    rd_byte = {24'b0, b0};
`endif
    rdata_d = rdata_q;
    if (do_acc && !acc.bad) begin
      if (acc.rd_b)      rdata_d = rd_byte;
      else if (acc.rd_w) rdata_d = {mem[a3], mem[a2], mem[a1], b0};
    end
    mem_we  = do_acc && !acc.bad && (acc.wr_b || acc.wr_w);
    ready_d = (state_q == DONE);
    err_d   = (state_q == DONE) && req_q.bad;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Storage is never cleared; reset on the access edge drops a pending store.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem[a0] <= acc.data[7:0];
      if (acc.wr_w) begin
        mem[a1] <= acc.data[15:8];
        mem[a2] <= acc.data[23:16];
        mem[a3] <= acc.data[31:24];
      end
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for the main flows, LATENCY=0 instance
// for the zero-wait and held-strobe cases.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] addr = '0, wdata = '0, rdata;
  logic        wb = 0, ww = 0, rb = 0, rw = 0, ready, err, busy;
  logic [31:0] addr1 = '0, wdata1 = '0, rdata1;
  logic        wb1 = 0, ww1 = 0, rb1 = 0, rw1 = 0, ready1, err1, busy1;

  int vec = 0;
  int miss = 0;

`ifdef DMEM_BYTE_SIGNEXT_EN
  localparam bit SX = 1'b1;
`else
  localparam bit SX = 1'b0;
`endif

  function automatic logic [31:0] bext(input logic [7:0] b);
    return SX ? {{24{b[7]}}, b} : {24'b0, b};
  endfunction

  dmem_responder #(.ADDR_BITS(8), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
    .mem_write_b(wb), .mem_write_w(ww), .mem_read_b(rb), .mem_read_w(rw),
    .rdata(rdata), .ready(ready), .err(err), .busy(busy));

  dmem_responder #(.ADDR_BITS(8), .LATENCY(0)) u_lat0 (
    .clk(clk), .reset(reset), .addr(addr1), .wdata(wdata1),
    .mem_write_b(wb1), .mem_write_w(ww1), .mem_read_b(rb1), .mem_read_w(rw1),
    .rdata(rdata1), .ready(ready1), .err(err1), .busy(busy1));

  // One request on u_lat2; lat = edges after capture until ready is seen, -1 on timeout.
  task automatic access(input logic s_wb, s_ww, s_rb, s_rw,
                        input logic [31:0] a, d, a_after, d_after,
                        output int lat, output logic [31:0] rd, output logic e);
    @(negedge clk);
    addr = a; wdata = d; wb = s_wb; ww = s_ww; rb = s_rb; rw = s_rw;
    @(posedge clk);
    #1;
    wb = 0; ww = 0; rb = 0; rw = 0; addr = a_after; wdata = d_after;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ready) begin lat = i - 1; break; end
    end
    rd = rdata; e = err;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vec++; if (rdata !== 32'h0) begin miss++; $display("FAIL reset_rdata: got %h want 00000000", rdata); end
    vec++; if ({ready, err, busy} !== 3'b000) begin miss++; $display("FAIL reset_flags: got %b want 000", {ready, err, busy}); end
    vec++; if ({rdata1, ready1, err1, busy1} !== 35'h0) begin miss++; $display("FAIL reset_lat0: got %h/%b want 0", rdata1, {ready1, err1, busy1}); end
    reset = 1'b0;
  endtask

  task automatic test_word;
    int lat; logic [31:0] rd; logic e;
    access(0, 1, 0, 0, 32'h10, 32'hDEADBEEF, 32'h10, 32'hDEADBEEF, lat, rd, e);
    vec++; if (lat !== 3) begin miss++; $display("FAIL word_store_lat: got %0d want 3", lat); end
    vec++; if (e !== 1'b0) begin miss++; $display("FAIL word_store_err: got %b want 0", e); end
    @(negedge clk);
    vec++; if (ready !== 1'b0) begin miss++; $display("FAIL ready_pulse_width: got %b want 0", ready); end
    access(0, 0, 0, 1, 32'h10, 32'h0, 32'h10, 32'h0, lat, rd, e);
    vec++; if (rd !== 32'hDEADBEEF || e !== 1'b0 || lat !== 3) begin miss++;
      $display("FAIL word_load: got %h err %b lat %0d want deadbeef err 0 lat 3", rd, e, lat); end
  endtask

  task automatic test_byte;
    int lat; logic [31:0] rd; logic e;
    access(1, 0, 0, 0, 32'h11, 32'h000000A5, 32'h11, 32'h000000A5, lat, rd, e);
    vec++; if (e !== 1'b0 || lat !== 3) begin miss++; $display("FAIL byte_store: got err %b lat %0d want err 0 lat 3", e, lat); end
    access(0, 0, 0, 1, 32'h10, 32'h0, 32'h10, 32'h0, lat, rd, e);
    vec++; if (rd !== 32'hDEADA5EF) begin miss++; $display("FAIL byte_merge: got %h want deada5ef", rd); end
    access(0, 0, 1, 0, 32'h11, 32'h0, 32'h11, 32'h0, lat, rd, e);
    vec++; if (rd !== bext(8'hA5)) begin miss++; $display("FAIL byte_load_11: got %h want %h", rd, bext(8'hA5)); end
    access(0, 0, 1, 0, 32'h13, 32'h0, 32'h13, 32'h0, lat, rd, e);
    vec++; if (rd !== bext(8'hDE) || e !== 1'b0) begin miss++; $display("FAIL byte_load_13: got %h err %b want %h err 0", rd, e, bext(8'hDE)); end
    access(0, 0, 1, 0, 32'h10, 32'h0, 32'h10, 32'h0, lat, rd, e);
    vec++; if (rd !== bext(8'hEF)) begin miss++; $display("FAIL byte_load_10: got %h want %h", rd, bext(8'hEF)); end
  endtask

  task automatic test_misaligned;
    int lat; logic [31:0] rd; logic e;
    access(0, 0, 0, 1, 32'h12, 32'h0, 32'h12, 32'h0, lat, rd, e);
    vec++; if (e !== 1'b1 || lat !== 3 || rd !== bext(8'hEF)) begin miss++;
      $display("FAIL misaligned_load: got %h err %b lat %0d want %h err 1 lat 3", rd, e, lat, bext(8'hEF)); end
    access(0, 1, 0, 0, 32'h13, 32'h12345678, 32'h13, 32'h12345678, lat, rd, e);
    vec++; if (e !== 1'b1) begin miss++; $display("FAIL misaligned_store_err: got %b want 1", e); end
    access(0, 0, 0, 1, 32'h10, 32'h0, 32'h10, 32'h0, lat, rd, e);
    vec++; if (rd !== 32'hDEADA5EF || e !== 1'b0) begin miss++; $display("FAIL misaligned_no_store: got %h err %b want deada5ef err 0", rd, e); end
  endtask

  task automatic test_multi;
    int lat; logic [31:0] rd; logic e;
    access(0, 1, 0, 0, 32'h20, 32'h11223344, 32'h20, 32'h11223344, lat, rd, e);
    access(0, 1, 0, 1, 32'h20, 32'hCAFEF00D, 32'h20, 32'hCAFEF00D, lat, rd, e);
    vec++; if (e !== 1'b1 || lat !== 3 || rd !== 32'hDEADA5EF) begin miss++;
      $display("FAIL multi_word: got %h err %b lat %0d want deada5ef err 1 lat 3", rd, e, lat); end
    access(1, 0, 1, 0, 32'h21, 32'h000000FF, 32'h21, 32'h000000FF, lat, rd, e);
    vec++; if (e !== 1'b1) begin miss++; $display("FAIL multi_byte_err: got %b want 1", e); end
    access(0, 0, 0, 1, 32'h20, 32'h0, 32'h20, 32'h0, lat, rd, e);
    vec++; if (rd !== 32'h11223344 || e !== 1'b0) begin miss++; $display("FAIL multi_no_store: got %h err %b want 11223344 err 0", rd, e); end
  endtask

  task automatic test_wrap;
    int lat; logic [31:0] rd; logic e;
    access(0, 0, 0, 1, 32'h00000110, 32'h0, 32'h00000110, 32'h0, lat, rd, e);
    vec++; if (rd !== 32'hDEADA5EF) begin miss++; $display("FAIL wrap_load: got %h want deada5ef", rd); end
    access(0, 1, 0, 0, 32'hFFFFFF40, 32'h89ABCDEF, 32'hFFFFFF40, 32'h89ABCDEF, lat, rd, e);
    access(0, 0, 0, 1, 32'h40, 32'h0, 32'h40, 32'h0, lat, rd, e);
    vec++; if (rd !== 32'h89ABCDEF) begin miss++; $display("FAIL wrap_store: got %h want 89abcdef", rd); end
  endtask

  task automatic test_addr_change;
    int lat; logic [31:0] rd; logic e;
    access(0, 0, 0, 1, 32'h20, 32'h0, 32'h10, 32'h0, lat, rd, e);
    vec++; if (rd !== 32'h11223344) begin miss++; $display("FAIL capture_load_addr: got %h want 11223344", rd); end
    access(0, 1, 0, 0, 32'h50, 32'h01020304, 32'h40, 32'hFFFFFFFF, lat, rd, e);
    access(0, 0, 0, 1, 32'h50, 32'h0, 32'h50, 32'h0, lat, rd, e);
    vec++; if (rd !== 32'h01020304) begin miss++; $display("FAIL capture_store_data: got %h want 01020304", rd); end
    access(0, 0, 0, 1, 32'h40, 32'h0, 32'h40, 32'h0, lat, rd, e);
    vec++; if (rd !== 32'h89ABCDEF) begin miss++; $display("FAIL capture_store_addr: got %h want 89abcdef", rd); end
  endtask

  task automatic test_reset_abort;
    int lat; int n_rdy; logic [31:0] rd; logic e;
    access(0, 1, 0, 0, 32'h30, 32'h55667788, 32'h30, 32'h55667788, lat, rd, e);
    @(negedge clk);
    addr = 32'h30; wdata = 32'hAAAAAAAA; ww = 1;
    @(posedge clk);
    #1 ww = 0;
    @(negedge clk);
    vec++; if (busy !== 1'b1) begin miss++; $display("FAIL abort_busy_wait: got %b want 1", busy); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vec++; if ({busy, ready, err} !== 3'b000 || rdata !== 32'h0) begin miss++;
      $display("FAIL abort_state: got busy/ready/err %b rdata %h want 000 00000000", {busy, ready, err}, rdata); end
    reset = 1'b0;
    n_rdy = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (ready) n_rdy++; end
    vec++; if (n_rdy !== 0) begin miss++; $display("FAIL abort_no_ready: got %0d readies want 0", n_rdy); end
    access(0, 0, 0, 1, 32'h30, 32'h0, 32'h30, 32'h0, lat, rd, e);
    vec++; if (rd !== 32'h55667788) begin miss++; $display("FAIL abort_no_store: got %h want 55667788", rd); end
  endtask

  task automatic test_lat0;
    @(negedge clk);
    addr1 = 32'h10; wdata1 = 32'h0BADCAFE; ww1 = 1;
    @(posedge clk);
    #1 ww1 = 0;
    @(negedge clk);
    vec++; if ({ready1, busy1} !== 2'b01) begin miss++; $display("FAIL lat0_done_cycle: got ready/busy %b want 01", {ready1, busy1}); end
    @(negedge clk);
    vec++; if ({ready1, err1} !== 2'b10) begin miss++; $display("FAIL lat0_ready: got ready/err %b want 10", {ready1, err1}); end
    @(negedge clk);
    addr1 = 32'h10; rw1 = 1;
    @(posedge clk);
    #1 rw1 = 0;
    @(negedge clk);
    @(negedge clk);
    vec++; if (ready1 !== 1'b1 || rdata1 !== 32'h0BADCAFE) begin miss++;
      $display("FAIL lat0_load: got ready %b rdata %h want 1 0badcafe", ready1, rdata1); end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  pat0;
    logic [11:0] pat2;
    @(negedge clk);
    addr1 = 32'h10; rb1 = 1;
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin @(negedge clk); pat0[i] = ready1; end
    rb1 = 0;
    vec++; if (pat0 !== 8'hAA) begin miss++; $display("FAIL held_lat0_pattern: got %b want 10101010", pat0); end
    vec++; if (rdata1 !== bext(8'hFE)) begin miss++; $display("FAIL held_lat0_rdata: got %h want %h", rdata1, bext(8'hFE)); end
    @(negedge clk);
    addr = 32'h40; rw = 1;
    @(posedge clk);
    for (int i = 0; i < 12; i++) begin @(negedge clk); pat2[i] = ready; end
    rw = 0;
    vec++; if (pat2 !== 12'h888) begin miss++; $display("FAIL held_lat2_pattern: got %b want 100010001000", pat2); end
    vec++; if (rdata !== 32'h89ABCDEF) begin miss++; $display("FAIL held_lat2_rdata: got %h want 89abcdef", rdata); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_word;
    test_byte;
    test_misaligned;
    test_multi;
    test_wrap;
    test_addr_change;
    test_reset_abort;
    test_lat0;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
